// File: rtl/siso_pkg.sv
// Shared types and sizing helpers for the SISO frame controller.
package siso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  function automatic int cnt_width(input int data_w, input int depth);
    return $clog2(data_w + depth + 1);
  endfunction
endpackage

// File: rtl/siso_en.sv
// DEPTH-stage serial-in/serial-out chain, advancing only when shift_en is high.
module siso_en #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic serial_in,
  output logic serial_out
);
  logic [DEPTH-1:0] r_stage;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage <= '0;
    end else if (shift_en) begin
      r_stage[0] <= serial_in;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign serial_out = r_stage[DEPTH-1];
endmodule

// File: rtl/siso_frame_ctrl.sv
// Load/shift/flush/capture sequencer: serialises a word through the SISO chain
// and reassembles the bits leaving the chain end into a parallel output word.
module siso_frame_ctrl
  import siso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              serial_mon
);
  localparam int N  = DATA_W + DEPTH;
  localparam int CW = cnt_width(DATA_W, DEPTH);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(N - 1);
  localparam logic [CW-1:0] CAP_START  = CW'(DEPTH);

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_tx, r_rx, r_out_data, w_rx_next;
  logic              r_out_valid;
  logic              w_shift_en, w_chain_in, w_mon, w_capture, w_frame_end;

  siso_en #(.DEPTH(DEPTH)) u_chain (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (w_shift_en),
    .serial_in (w_chain_in),
    .serial_out(w_mon)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_chain_in = 1'b0;
    case (r_state)
      IDLE:  if (in_valid) w_next = SHIFT;
      SHIFT: begin
        w_shift_en = 1'b1;
        w_chain_in = (LSB_FIRST != 0) ? r_tx[0] : r_tx[DATA_W-1];
        if (r_cnt == LAST_SHIFT) w_next = FLUSH;
      end
      FLUSH: begin
        w_shift_en = 1'b1;
        if (r_cnt == LAST_FLUSH) w_next = DONE;
      end
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The first data bit reaches the chain end DEPTH cycles into the frame.
  assign w_capture   = w_shift_en && (r_cnt >= CAP_START);
  assign w_frame_end = (r_state == FLUSH) && (r_cnt == LAST_FLUSH);
  assign w_rx_next   = (LSB_FIRST != 0) ? {w_mon, r_rx[DATA_W-1:1]}
                                        : {r_rx[DATA_W-2:0], w_mon};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_tx  <= in_data;
        r_rx  <= '0;
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + CW'(1);
        r_tx  <= (LSB_FIRST != 0) ? (r_tx >> 1) : (r_tx << 1);
        if (w_capture) r_rx <= w_rx_next;
      end
      // Output word is latched once per frame so it stays put across the handshake.
      if (w_frame_end) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rx_next;
      end else if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state == SHIFT) || (r_state == FLUSH);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign serial_mon = w_mon;
endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Bench: two controllers (MSB-first DEPTH=4, LSB-first DEPTH=1) against a frame-level reference.
module tb_siso_frame_ctrl;
  localparam int W  = 8;
  localparam int DA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0]      iv, ir, ov, ordy, bsy, mon;
  logic [W-1:0]    id [2];
  logic [W-1:0]    od [2];

  int checks = 0;
  int errors = 0;

  siso_frame_ctrl #(.DATA_W(W), .DEPTH(DA), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0]),
    .serial_mon(mon[0])
  );

  siso_frame_ctrl #(.DATA_W(W), .DEPTH(1), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1]),
    .serial_mon(mon[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chain-end bit expected in frame cycle c: bit k of the word emerges at cycle d+k,
  // zeros elsewhere because the chain is empty between frames.
  function automatic logic ref_mon(input logic [W-1:0] w, input int c, input int d, input bit lsb);
    int k;
    if (c < d || c >= d + W) return 1'b0;
    k = c - d;
    return lsb ? w[k] : w[W-1-k];
  endfunction

  // Runs one frame on DUT s; entered and left at a negedge with the DUT idle.
  task automatic frame(input int s, input logic [W-1:0] w, input int hold,
                       input bit junk, input bit keep_iv);
    int d;
    int n;
    d = (s == 1) ? 1 : DA;
    n = W + d;
    chk($sformatf("idle_in_ready[%0d]", s), 32'(ir[s]), 1);
    id[s]   = w;
    iv[s]   = 1'b1;
    ordy[s] = (hold == 0);
    @(negedge clk);
    if (!keep_iv) iv[s] = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk($sformatf("busy[%0d] c=%0d", s, c), 32'(bsy[s]), 1);
      chk($sformatf("in_ready_busy[%0d] c=%0d", s, c), 32'(ir[s]), 0);
      chk($sformatf("out_valid_early[%0d] c=%0d", s, c), 32'(ov[s]), 0);
      chk($sformatf("serial_mon[%0d] w=%0h c=%0d", s, w, c), 32'(mon[s]),
          32'(ref_mon(w, c, d, s == 1)));
      if (junk && c == 2) begin iv[s] = 1'b1; id[s] = 8'h12; end
      if (junk && c == 3) begin iv[s] = 1'b0; id[s] = w; end
      @(negedge clk);
    end
    chk($sformatf("out_valid[%0d] w=%0h", s, w), 32'(ov[s]), 1);
    chk($sformatf("out_data[%0d] w=%0h", s, w), 32'(od[s]), 32'(w));
    chk($sformatf("busy_done[%0d]", s), 32'(bsy[s]), 0);
    chk($sformatf("in_ready_done[%0d]", s), 32'(ir[s]), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("hold_valid[%0d] h=%0d", s, h), 32'(ov[s]), 1);
      chk($sformatf("hold_data[%0d] h=%0d", s, h), 32'(od[s]), 32'(w));
      chk($sformatf("hold_in_ready[%0d] h=%0d", s, h), 32'(ir[s]), 0);
    end
    ordy[s] = 1'b1;
    @(negedge clk);
    ordy[s] = 1'b0;
    chk($sformatf("valid_drop[%0d]", s), 32'(ov[s]), 0);
    chk($sformatf("in_ready_back[%0d]", s), 32'(ir[s]), 1);
    chk($sformatf("data_kept[%0d]", s), 32'(od[s]), 32'(w));
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s in_ready[%0d]", tag, s), 32'(ir[s]), 1);
      chk($sformatf("%s out_valid[%0d]", tag, s), 32'(ov[s]), 0);
      chk($sformatf("%s out_data[%0d]", tag, s), 32'(od[s]), 0);
      chk($sformatf("%s busy[%0d]", tag, s), 32'(bsy[s]), 0);
      chk($sformatf("%s serial_mon[%0d]", tag, s), 32'(mon[s]), 0);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    reset = 1'b0;
    iv = '0; ordy = '0; id[0] = '0; id[1] = '0;
    #1;
    chk_reset_vals("reset");
    #11 reset = 1'b1;
    @(negedge clk);

    frame(0, 8'hA5, 0, 1'b0, 1'b0);        // basic frame
    frame(0, 8'h3C, 5, 1'b0, 1'b0);        // backpressure
    frame(0, 8'hFF, 0, 1'b0, 1'b1);        // back-to-back with in_valid held
    frame(0, 8'h00, 0, 1'b0, 1'b0);
    frame(0, 8'h81, 1, 1'b1, 1'b0);        // in_valid pulse while busy

    // Abort a 0xC3 frame at cnt=3 with an asynchronous reset.
    id[0] = 8'hC3; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort busy", 32'(bsy[0]), 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_abort");
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("post_abort idle", 32'(ov[0]), 0);
    frame(0, 8'h5A, 0, 1'b0, 1'b0);

    frame(1, 8'h01, 0, 1'b0, 1'b0);        // LSB first, DEPTH=1

    for (int i = 0; i < 8; i++) begin
      w = W'($urandom);
      frame(i % 2, w, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
